// File: rtl/qspi_pkg.sv
// Shared constants for the QSPI write sequencer: FSM encodings,
// command codes and the address-window defaults.
package qspi_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCEPT  = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;

    localparam logic CMD_WRITE = 1'b0;
    localparam logic CMD_READ  = 1'b1;

    localparam logic [31:0] AUDIO_MAGIC_ADDR = 32'hA0D1_0000;
    localparam logic [7:0]  WIN_TAG_DEF      = 8'h00;

endpackage

// File: rtl/qsw_fifo.sv
// Synchronous FIFO with registered storage and an occupancy count.
// Push while full is accepted only when a pop frees a slot that cycle.
module qsw_fifo #(
    parameter int W  = 33,
    parameter int AW = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [W-1:0]  dout_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [AW:0]   count_o
);

    logic [W-1:0]  mem_q [2**AW];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(2**AW));
    assign count_o = count_q;
    assign dout_o  = mem_q[rptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + AW'(1);
        if (do_pop)  rptr_d = rptr_q + AW'(1);
        if (do_push && !do_pop)
            count_d = count_q + (AW+1)'(1);
        else if (do_pop && !do_push)
            count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/qspi_write_sequencer.sv
// Turns QSPI host write headers plus data words into a stream of
// auto-incrementing RAM word writes, buffered through a small FIFO.
module qspi_write_sequencer
    import qspi_pkg::*;
#(
    parameter int         ADDR_W  = 17,
    parameter int         FIFO_AW = 4,
    parameter logic [7:0] WIN_TAG = WIN_TAG_DEF
) (
    input  logic              hClk,
    input  logic              hRst_n,
    input  logic              hdr_valid,
    input  logic              hdr_cmd,
    input  logic [9:0]        hdr_len,
    input  logic [31:0]       hdr_addr,
    input  logic              wr_valid,
    input  logic [15:0]       wr_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic              clr_status,
    output logic              busy,
    output logic              xfer_done,
    output logic              ovf_err,
    output logic              len_err
);

    localparam int FW = ADDR_W + 16;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [9:0]        rem_q, rem_d;
    logic              done_q, done_d;
    logic              ovf_q, len_q;
    logic              ovf_set, len_set;

    logic              push, pop;
    logic              f_empty, f_full;
    logic [FIFO_AW:0]  f_count;
    logic [FW-1:0]     f_head;
    logic              hdr_ok;
    logic              last_pop;
    logic              unused_hdr_bits;

    qsw_fifo #(
        .W  (FW),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk_i   (hClk),
        .rst_ni  (hRst_n),
        .push_i  (push),
        .din_i   ({addr_q, wr_data}),
        .pop_i   (pop),
        .dout_o  (f_head),
        .empty_o (f_empty),
        .full_o  (f_full),
        .count_o (f_count)
    );

    assign unused_hdr_bits = ^{hdr_addr[0], hdr_addr[23:ADDR_W+1]};

    assign pop      = mem_ack & ~f_empty;
    assign last_pop = pop & (f_count == (FIFO_AW+1)'(1));
    assign hdr_ok   = (hdr_cmd == CMD_WRITE)
                    && (hdr_addr[31:24] == WIN_TAG)
                    && (hdr_addr != AUDIO_MAGIC_ADDR);

    // The word of the current transfer is handled before a coincident header.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        push    = 1'b0;
        ovf_set = 1'b0;
        len_set = 1'b0;

        if (wr_valid) begin
            if (state_q == ST_ACCEPT) begin
                push    = 1'b1;
                ovf_set = f_full & ~pop;
                addr_d  = addr_q + ADDR_W'(1);
                if (rem_q == '0)
                    state_d = ST_DRAIN;
                else
                    rem_d = rem_q - 10'd1;
            end else if (state_q == ST_DRAIN) begin
                len_set = 1'b1;
            end
        end

        if (state_q == ST_DRAIN && (f_empty || last_pop)) begin
            state_d = ST_IDLE;
            done_d  = last_pop;
        end

        if (hdr_valid) begin
            done_d = 1'b0;
            if (state_d == ST_ACCEPT) len_set = 1'b1;
            if (hdr_ok) begin
                addr_d  = hdr_addr[ADDR_W:1];
                rem_d   = hdr_len;
                state_d = ST_ACCEPT;
            end else begin
                state_d = ST_DISCARD;
            end
        end
    end

    always_ff @(posedge hClk or negedge hRst_n) begin
        if (!hRst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            len_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            ovf_q   <= ovf_set | (ovf_q & ~clr_status);
            len_q   <= len_set | (len_q & ~clr_status);
        end
    end

    assign mem_req   = ~f_empty;
    assign mem_addr  = f_empty ? '0 : f_head[FW-1:16];
    assign mem_wdata = f_empty ? '0 : f_head[15:0];
    assign busy      = (state_q != ST_IDLE) | ~f_empty;
    assign xfer_done = done_q;
    assign ovf_err   = ovf_q;
    assign len_err   = len_q;

endmodule

// File: tb/tb_qspi_write_sequencer.sv
// Directed bench for qspi_write_sequencer with a write monitor.
module tb_qspi_write_sequencer;

    logic        hClk = 1'b0;
    logic        hRst_n;
    logic        hdr_valid, hdr_cmd;
    logic [9:0]  hdr_len;
    logic [31:0] hdr_addr;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic        mem_req;
    logic [16:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack, clr_status;
    logic        busy, xfer_done, ovf_err, len_err;

    int total = 0;
    int fails = 0;
    int done_cnt = 0;
    logic [32:0] wq[$];

    always #5 hClk = ~hClk;

    qspi_write_sequencer dut (
        .hClk       (hClk),
        .hRst_n     (hRst_n),
        .hdr_valid  (hdr_valid),
        .hdr_cmd    (hdr_cmd),
        .hdr_len    (hdr_len),
        .hdr_addr   (hdr_addr),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .clr_status (clr_status),
        .busy       (busy),
        .xfer_done  (xfer_done),
        .ovf_err    (ovf_err),
        .len_err    (len_err)
    );

    // Mid-cycle monitor: what the next rising edge will commit.
    always @(negedge hClk) begin
        if (mem_req && mem_ack) wq.push_back({mem_addr, mem_wdata});
        if (xfer_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge hClk);
        #2;
    endtask

    task automatic hdr(input logic c, input logic [9:0] l,
                       input logic [31:0] a);
        hdr_valid = 1'b1; hdr_cmd = c; hdr_len = l; hdr_addr = a;
        tick();
        hdr_valid = 1'b0;
    endtask

    task automatic word(input logic [15:0] d);
        wr_valid = 1'b1; wr_data = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic chk_wr(input string tag, input int idx,
                          input logic [16:0] a, input logic [15:0] d);
        logic [32:0] e;
        e = {a, d};
        if (idx < wq.size())
            chk(tag, 32'(wq[idx]), 32'(e));
        else
            chk({tag, "_missing"}, 32'hFFFF_FFFF, 32'(e));
    endtask

    initial begin
        hRst_n = 1'b0; hdr_valid = 0; hdr_cmd = 0; hdr_len = 0;
        hdr_addr = 0; wr_valid = 0; wr_data = 0; mem_ack = 0;
        clr_status = 0;
        #3;
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_flags", {29'd0, xfer_done, ovf_err, len_err}, 0);
        tick(); tick();
        hRst_n = 1'b1;
        tick();

        // basic write
        mem_ack = 1'b1;
        wq.delete(); done_cnt = 0;
        hdr(1'b0, 10'd3, 32'h0000_0100);
        word(16'hA1A1); word(16'hA2A2); word(16'hA3A3); word(16'hA4A4);
        chk("b_lastreq", 32'(mem_req), 1);
        chk("b_lastaddr", 32'(mem_addr), 32'h083);
        chk("b_done_early", 32'(xfer_done), 0);
        tick();
        chk("b_done", 32'(xfer_done), 1);
        chk("b_busy", 32'(busy), 0);
        tick();
        chk("b_done_pulse", 32'(xfer_done), 0);
        chk("b_nwr", wq.size(), 4);
        chk_wr("b_w0", 0, 17'h080, 16'hA1A1);
        chk_wr("b_w1", 1, 17'h081, 16'hA2A2);
        chk_wr("b_w2", 2, 17'h082, 16'hA3A3);
        chk_wr("b_w3", 3, 17'h083, 16'hA4A4);

        // backpressure and overflow
        mem_ack = 1'b0;
        hdr(1'b0, 10'd19, 32'h0000_0200);
        for (int i = 0; i < 20; i++) word(16'hB000 + 16'(i));
        chk("bp_ovf", 32'(ovf_err), 1);
        chk("bp_req", 32'(mem_req), 1);
        chk("bp_head", 32'(mem_addr), 32'h100);
        wq.delete(); done_cnt = 0;
        mem_ack = 1'b1;
        repeat (20) tick();
        chk("bp_nwr", wq.size(), 16);
        for (int i = 0; i < 16; i++)
            chk_wr($sformatf("bp_w%0d", i), i,
                   17'h100 + 17'(i), 16'hB000 + 16'(i));
        chk("bp_done", done_cnt, 1);
        chk("bp_busy", 32'(busy), 0);
        clr_status = 1'b1; tick(); clr_status = 1'b0;
        chk("bp_clr", 32'(ovf_err), 0);

        // audio read and out-of-window write are discarded
        wq.delete();
        hdr(1'b1, 10'h015, 32'hA0D1_0000);
        for (int i = 0; i < 8; i++) word(16'hC0C0);
        tick();
        chk("rd_nwr", wq.size(), 0);
        chk("rd_req", 32'(mem_req), 0);
        chk("rd_flags", {30'd0, ovf_err, len_err}, 0);
        hdr(1'b0, 10'd0, 32'h0100_0000);
        word(16'h1234); word(16'h5678);
        tick();
        chk("win_nwr", wq.size(), 0);
        chk("win_flags", {30'd0, ovf_err, len_err}, 0);

        // truncation by a new header
        wq.delete(); done_cnt = 0;
        hdr(1'b0, 10'd7, 32'h0000_0040);
        word(16'hC1C1); word(16'hC2C2); word(16'hC3C3);
        hdr(1'b0, 10'd0, 32'h0000_0020);
        word(16'hD1D1);
        repeat (3) tick();
        chk("tr_nwr", wq.size(), 4);
        chk_wr("tr_w0", 0, 17'h020, 16'hC1C1);
        chk_wr("tr_w2", 2, 17'h022, 16'hC3C3);
        chk_wr("tr_w3", 3, 17'h010, 16'hD1D1);
        chk("tr_len", 32'(len_err), 1);
        chk("tr_done", done_cnt, 1);
        clr_status = 1'b1; tick(); clr_status = 1'b0;

        // last word and new header in the same cycle, then over-length
        wq.delete(); done_cnt = 0;
        hdr(1'b0, 10'd1, 32'h0000_0080);
        word(16'hE1E1);
        wr_valid = 1'b1; wr_data = 16'hE2E2;
        hdr(1'b0, 10'd1, 32'h0000_0100);
        word(16'hF1F1); word(16'hF2F2);
        chk("sc_len0", 32'(len_err), 0);
        word(16'hF3F3);
        chk("sc_len1", 32'(len_err), 1);
        repeat (3) tick();
        chk("sc_nwr", wq.size(), 4);
        chk_wr("sc_w1", 1, 17'h041, 16'hE2E2);
        chk_wr("sc_w2", 2, 17'h080, 16'hF1F1);
        chk_wr("sc_w3", 3, 17'h081, 16'hF2F2);
        chk("sc_done", done_cnt, 1);
        clr_status = 1'b1; tick(); clr_status = 1'b0;

        // address wrap
        wq.delete();
        hdr(1'b0, 10'd1, 32'h0003_FFFE);
        word(16'h1111); word(16'h2222);
        repeat (3) tick();
        chk("wr_nwr", wq.size(), 2);
        chk_wr("wr_w0", 0, 17'h1FFFF, 16'h1111);
        chk_wr("wr_w1", 1, 17'h00000, 16'h2222);

        // asynchronous reset with a partly filled FIFO
        mem_ack = 1'b0;
        hdr(1'b0, 10'd7, 32'h0000_0000);
        for (int i = 0; i < 5; i++) word(16'h5500 + 16'(i));
        hdr(1'b0, 10'd0, 32'h0000_0000);
        chk("ar_req_pre", 32'(mem_req), 1);
        chk("ar_len_pre", 32'(len_err), 1);
        #1 hRst_n = 1'b0;
        #1;
        chk("ar_req", 32'(mem_req), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_flags", {29'd0, xfer_done, ovf_err, len_err}, 0);
        tick();
        hRst_n = 1'b1;

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
